// File: rtl/me_stage_pkg.sv
// ---------------------------------------------------------------------------
// me_stage_pkg
//   Shared encodings for the MIPS memory-access stage:
//     - load width codes carried on EX_MemDataWidth
//     - partial-word merge codes carried on EX_MemDataCombine (LWL/LWR)
//     - bit positions inside EX_SpecialRegSel
// ---------------------------------------------------------------------------
package me_stage_pkg;

  typedef enum logic [2:0] {
    BYTE_U = 3'b000,
    BYTE_S = 3'b001,
    HALF_S = 3'b011,
    HALF_U = 3'b100,
    WORD   = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    LWL    = 2'b01,
    LWR    = 2'b10
  } mem_combine_e;

  localparam int unsigned SEL_LO_BIT = 0;
  localparam int unsigned SEL_HI_BIT = 1;

endpackage : me_stage_pkg

// File: rtl/me_stage_load_align.sv
// ---------------------------------------------------------------------------
// me_stage_load_align
//   Purely combinational load-data formatter. Picks the addressed byte or
//   halfword out of the SRAM read word and sign/zero extends it, or performs
//   the LWL/LWR merge of memory bytes into the old rt value.
//
//   Ports:
//     rdata_i    32  SRAM read word (bytes m3..m0, m0 = rdata_i[7:0])
//     addr_i      2  low address bits of the access
//     width_i     3  load width code (mem_width_e)
//     combine_i   2  merge code (mem_combine_e)
//     rt_i       32  current rt value, used by LWL/LWR
//     result_o   32  formatted load data
// ---------------------------------------------------------------------------
module me_stage_load_align
  import me_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_width_e  width_i,
  input  logic [1:0]  combine_i,
  input  logic [31:0] rt_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword loads are only architecturally legal at a=0 or a=2, so addr[1]
  // alone chooses the half.
  assign byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    result_o = rdata_i;
    case (combine_i)
      LWL: begin
        // Low-order memory bytes move into the high end of rt.
        case (addr_i)
          2'd0:    result_o = {rdata_i[7:0],  rt_i[23:0]};
          2'd1:    result_o = {rdata_i[15:0], rt_i[15:0]};
          2'd2:    result_o = {rdata_i[23:0], rt_i[7:0]};
          default: result_o = rdata_i;
        endcase
      end
      LWR: begin
        // High-order memory bytes move into the low end of rt.
        case (addr_i)
          2'd0:    result_o = rdata_i;
          2'd1:    result_o = {rt_i[31:24], rdata_i[31:8]};
          2'd2:    result_o = {rt_i[31:16], rdata_i[31:16]};
          default: result_o = {rt_i[31:8],  rdata_i[31:24]};
        endcase
      end
      default: begin
        case (width_i)
          BYTE_U:  result_o = {24'h0, byte_sel};
          BYTE_S:  result_o = {{24{byte_sel[7]}}, byte_sel};
          HALF_S:  result_o = {{16{half_sel[15]}}, half_sel};
          HALF_U:  result_o = {16'h0, half_sel};
          default: result_o = rdata_i;
        endcase
      end
    endcase
  end

endmodule : me_stage_load_align

// File: rtl/me_stage.sv
// ---------------------------------------------------------------------------
// me_stage
//   Memory-access stage of the 5-stage MIPS pipeline. Latches the execute
//   payload through the valid/allowin handshake, formats synchronous SRAM
//   load data (including LWL/LWR), owns HI/LO and commits mul/div/MTHI/MTLO
//   results, and presents the write-back payload.
//
//   Ports:
//     clk, reset                    clock, asynchronous active-high reset
//     EX_to_ME_valid, WB_allowin    upstream valid / downstream ready
//     WB_ExcepEN                    flush from write-back (exception/ERET)
//     EX_*                          execute-stage payload
//     data_sram_rdata               SRAM read word, valid while in ME
//     ME_MulRes                     64-bit multiplier result, valid in ME
//     ME_allowin, ME_to_WB_valid    handshake outputs
//     ME_valid, ME_PC, ME_WriteReg  latched instruction state
//     ME_RegWrite, ME_Result        GPR write enable and write data
//     ME_Excep                      latched exception flag
//     ME_HI, ME_LO                  architectural HI/LO
// ---------------------------------------------------------------------------
module me_stage
  import me_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_to_ME_valid,
  input  logic        WB_allowin,
  input  logic        WB_ExcepEN,
  input  logic [31:0] EX_PC,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemToReg,
  input  logic        EX_WriPCPlus8,
  input  logic [31:0] EX_aluResult,
  input  logic [31:0] EX_rdata2,
  input  logic [2:0]  EX_MemDataWidth,
  input  logic [1:0]  EX_MemDataCombine,
  input  logic        EX_SpecialRegWri,
  input  logic        EX_SpecialRegRead,
  input  logic [1:0]  EX_SpecialRegSel,
  input  logic        EX_Mul,
  input  logic        EX_Div,
  input  logic [31:0] EX_LOVal,
  input  logic [31:0] EX_HIVal,
  input  logic        EX_Excep,
  input  logic [31:0] data_sram_rdata,
  input  logic [63:0] ME_MulRes,
  output logic        ME_allowin,
  output logic        ME_to_WB_valid,
  output logic        ME_valid,
  output logic [31:0] ME_PC,
  output logic [4:0]  ME_WriteReg,
  output logic        ME_RegWrite,
  output logic [31:0] ME_Result,
  output logic        ME_Excep,
  output logic [31:0] ME_HI,
  output logic [31:0] ME_LO
);

  // Handshake / valid
  logic        valid_q, valid_d;
  logic        load_en;
  logic        commit;

  // Latched payload
  logic [31:0] pc_q;
  logic [4:0]  wreg_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic        link_q;
  logic [31:0] alu_q;
  logic [31:0] rt_q;
  mem_width_e  width_q;
  logic [1:0]  combine_q;
  logic        sp_wri_q;
  logic        sp_read_q;
  logic [1:0]  sel_q;
  logic        mul_q;
  logic        div_q;
  logic [31:0] lo_val_q;
  logic [31:0] hi_val_q;
  logic        excep_q;

  // HI/LO
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Stall capture of SRAM read data
  logic [31:0] rdata_cap_q;
  logic        rdata_held_q;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;

  // ready_go is constant 1, so the stage only ever waits on write-back.
  assign ME_allowin     = !valid_q || WB_allowin;
  assign ME_to_WB_valid = valid_q;
  assign load_en        = EX_to_ME_valid && ME_allowin;
  assign commit         = valid_q && WB_allowin && !excep_q && !WB_ExcepEN;

  always_comb begin
    valid_d = valid_q;
    if (ME_allowin) valid_d = EX_to_ME_valid && !WB_ExcepEN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      wreg_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      alu_q        <= '0;
      rt_q         <= '0;
      width_q      <= BYTE_U;
      combine_q    <= NORMAL;
      sp_wri_q     <= 1'b0;
      sp_read_q    <= 1'b0;
      sel_q        <= '0;
      mul_q        <= 1'b0;
      div_q        <= 1'b0;
      lo_val_q     <= '0;
      hi_val_q     <= '0;
      excep_q      <= 1'b0;
    end else if (load_en) begin
      pc_q         <= EX_PC;
      wreg_q       <= EX_WriteReg;
      reg_write_q  <= EX_RegWrite;
      mem_to_reg_q <= EX_MemToReg;
      link_q       <= EX_WriPCPlus8;
      alu_q        <= EX_aluResult;
      rt_q         <= EX_rdata2;
      width_q      <= mem_width_e'(EX_MemDataWidth);
      combine_q    <= EX_MemDataCombine;
      sp_wri_q     <= EX_SpecialRegWri;
      sp_read_q    <= EX_SpecialRegRead;
      sel_q        <= EX_SpecialRegSel;
      mul_q        <= EX_Mul;
      div_q        <= EX_Div;
      lo_val_q     <= EX_LOVal;
      hi_val_q     <= EX_HIVal;
      excep_q      <= EX_Excep;
    end
  end

  // The SRAM only presents the word for one cycle after the address was
  // issued. On the first stalled cycle grab it; while the held flag is set
  // the captured copy replaces the live bus. Leaving ME clears the flag.
  // NOTE: the capture word is reset along with everything else; it is a
  // single register, not a memory array, so reset costs nothing and keeps
  // ME_Result deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_held_q <= 1'b0;
      rdata_cap_q  <= '0;
    end else if (ME_allowin) begin
      rdata_held_q <= 1'b0;
    end else if (!rdata_held_q) begin
      rdata_held_q <= 1'b1;
      rdata_cap_q  <= data_sram_rdata;
    end
  end

  assign rdata_eff = rdata_held_q ? rdata_cap_q : data_sram_rdata;

  me_stage_load_align u_load_align (
    .rdata_i   (rdata_eff),
    .addr_i    (alu_q[1:0]),
    .width_i   (width_q),
    .combine_i (combine_q),
    .rt_i      (rt_q),
    .result_o  (load_data)
  );

  // HI/LO commit: multiply wins over divide, divide over MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (mul_q) begin
        {hi_d, lo_d} = ME_MulRes;
      end else if (div_q) begin
        hi_d = hi_val_q;
        lo_d = lo_val_q;
      end else if (sp_wri_q) begin
        if (sel_q[SEL_LO_BIT]) lo_d = lo_val_q;
        if (sel_q[SEL_HI_BIT]) hi_d = hi_val_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Result mux; MFHI/MFLO read the committed HI/LO directly.
  always_comb begin
    ME_Result = alu_q;
    if (sp_read_q) begin
      ME_Result = sel_q[SEL_HI_BIT] ? hi_q : lo_q;
    end else if (link_q) begin
      ME_Result = pc_q + 32'd8;
    end else if (mem_to_reg_q) begin
      ME_Result = load_data;
    end
  end

  assign ME_valid    = valid_q;
  assign ME_PC       = pc_q;
  assign ME_WriteReg = wreg_q;
  assign ME_RegWrite = valid_q && reg_write_q && !excep_q;
  assign ME_Excep    = excep_q;
  assign ME_HI       = hi_q;
  assign ME_LO       = lo_q;

endmodule : me_stage

// File: tb/tb_me_stage.sv
// ---------------------------------------------------------------------------
// tb_me_stage
//   Directed bench for me_stage: a table of load/ALU/link vectors with
//   hand-computed results, followed by hand-written sequences for HI/LO
//   commit, stall data capture, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_me_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_to_ME_valid, WB_allowin, WB_ExcepEN;
  logic [31:0] EX_PC;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_MemToReg, EX_WriPCPlus8;
  logic [31:0] EX_aluResult, EX_rdata2;
  logic [2:0]  EX_MemDataWidth;
  logic [1:0]  EX_MemDataCombine;
  logic        EX_SpecialRegWri, EX_SpecialRegRead;
  logic [1:0]  EX_SpecialRegSel;
  logic        EX_Mul, EX_Div;
  logic [31:0] EX_LOVal, EX_HIVal;
  logic        EX_Excep;
  logic [31:0] data_sram_rdata;
  logic [63:0] ME_MulRes;
  logic        ME_allowin, ME_to_WB_valid, ME_valid;
  logic [31:0] ME_PC;
  logic [4:0]  ME_WriteReg;
  logic        ME_RegWrite;
  logic [31:0] ME_Result;
  logic        ME_Excep;
  logic [31:0] ME_HI, ME_LO;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  me_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_to_ME_valid    (EX_to_ME_valid),
    .WB_allowin        (WB_allowin),
    .WB_ExcepEN        (WB_ExcepEN),
    .EX_PC             (EX_PC),
    .EX_WriteReg       (EX_WriteReg),
    .EX_RegWrite       (EX_RegWrite),
    .EX_MemToReg       (EX_MemToReg),
    .EX_WriPCPlus8     (EX_WriPCPlus8),
    .EX_aluResult      (EX_aluResult),
    .EX_rdata2         (EX_rdata2),
    .EX_MemDataWidth   (EX_MemDataWidth),
    .EX_MemDataCombine (EX_MemDataCombine),
    .EX_SpecialRegWri  (EX_SpecialRegWri),
    .EX_SpecialRegRead (EX_SpecialRegRead),
    .EX_SpecialRegSel  (EX_SpecialRegSel),
    .EX_Mul            (EX_Mul),
    .EX_Div            (EX_Div),
    .EX_LOVal          (EX_LOVal),
    .EX_HIVal          (EX_HIVal),
    .EX_Excep          (EX_Excep),
    .data_sram_rdata   (data_sram_rdata),
    .ME_MulRes         (ME_MulRes),
    .ME_allowin        (ME_allowin),
    .ME_to_WB_valid    (ME_to_WB_valid),
    .ME_valid          (ME_valid),
    .ME_PC             (ME_PC),
    .ME_WriteReg       (ME_WriteReg),
    .ME_RegWrite       (ME_RegWrite),
    .ME_Result         (ME_Result),
    .ME_Excep          (ME_Excep),
    .ME_HI             (ME_HI),
    .ME_LO             (ME_LO)
  );

  typedef struct {
    logic        mem_to_reg, link, reg_write, sp_wri, sp_read, mul, div, excep;
    logic [2:0]  width;
    logic [1:0]  comb, sel;
    logic [4:0]  wreg;
    logic [31:0] pc, alu, rt, lo, hi;
  } ex_t;

  typedef struct {
    logic        mem_to_reg, link;
    logic [2:0]  width;
    logic [1:0]  comb;
    logic [31:0] alu, rdata, rt, pc, exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic ex_t blank();
    ex_t e;
    e = '{mem_to_reg: 1'b0, link: 1'b0, reg_write: 1'b0, sp_wri: 1'b0,
          sp_read: 1'b0, mul: 1'b0, div: 1'b0, excep: 1'b0, width: 3'b000,
          comb: 2'b00, sel: 2'b00, wreg: 5'd0, pc: 32'h0, alu: 32'h0,
          rt: 32'h0, lo: 32'h0, hi: 32'h0};
    return e;
  endfunction

  function automatic vec_t mk(input logic m2r, input logic lnk,
                              input logic [2:0] w, input logic [1:0] c,
                              input logic [31:0] alu, input logic [31:0] rd,
                              input logic [31:0] rt, input logic [31:0] pc,
                              input logic [31:0] exp);
    vec_t v;
    v = '{mem_to_reg: m2r, link: lnk, width: w, comb: c, alu: alu,
          rdata: rd, rt: rt, pc: pc, exp: exp};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input ex_t e);
    EX_PC             = e.pc;
    EX_WriteReg       = e.wreg;
    EX_RegWrite       = e.reg_write;
    EX_MemToReg       = e.mem_to_reg;
    EX_WriPCPlus8     = e.link;
    EX_aluResult      = e.alu;
    EX_rdata2         = e.rt;
    EX_MemDataWidth   = e.width;
    EX_MemDataCombine = e.comb;
    EX_SpecialRegWri  = e.sp_wri;
    EX_SpecialRegRead = e.sp_read;
    EX_SpecialRegSel  = e.sel;
    EX_Mul            = e.mul;
    EX_Div            = e.div;
    EX_LOVal          = e.lo;
    EX_HIVal          = e.hi;
    EX_Excep          = e.excep;
  endtask

  // Present one instruction for a single edge; returns 1 time unit after the
  // edge that latched it into ME.
  task automatic issue(input ex_t e);
    @(negedge clk);
    drive(e);
    EX_to_ME_valid = 1'b1;
    @(posedge clk);
    #1;
    EX_to_ME_valid = 1'b0;
  endtask

  // Let the instruction in ME leave (WB_allowin must be 1).
  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ex_t e;

    // Width codes: 000 LBU, 001 LB, 011 LH, 100 LHU, 101 LW; comb 01 LWL, 10 LWR.
    vecs[0]  = mk(1, 0, 3'b001, 2'b00, 32'h1000_0003, 32'h80FF_1234, 32'h0, 32'h100, 32'hFFFF_FF80);
    vecs[1]  = mk(1, 0, 3'b000, 2'b00, 32'h1000_0003, 32'h80FF_1234, 32'h0, 32'h104, 32'h0000_0080);
    vecs[2]  = mk(1, 0, 3'b001, 2'b00, 32'h1000_0001, 32'h80FF_1234, 32'h0, 32'h108, 32'h0000_0012);
    vecs[3]  = mk(1, 0, 3'b011, 2'b00, 32'h1000_0002, 32'h80FF_1234, 32'h0, 32'h10C, 32'hFFFF_80FF);
    vecs[4]  = mk(1, 0, 3'b100, 2'b00, 32'h1000_0000, 32'h80FF_9234, 32'h0, 32'h110, 32'h0000_9234);
    vecs[5]  = mk(1, 0, 3'b011, 2'b00, 32'h1000_0000, 32'h80FF_9234, 32'h0, 32'h114, 32'hFFFF_9234);
    vecs[6]  = mk(1, 0, 3'b101, 2'b00, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 32'h118, 32'hDEAD_BEEF);
    vecs[7]  = mk(1, 0, 3'b101, 2'b01, 32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'h11C, 32'hCCDD_3344);
    vecs[8]  = mk(1, 0, 3'b101, 2'b10, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h120, 32'h1122_AABB);
    vecs[9]  = mk(1, 0, 3'b101, 2'b01, 32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 32'h124, 32'hDD22_3344);
    vecs[10] = mk(1, 0, 3'b101, 2'b01, 32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 32'h128, 32'hAABB_CCDD);
    vecs[11] = mk(1, 0, 3'b101, 2'b10, 32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 32'h12C, 32'h1122_33AA);
    vecs[12] = mk(1, 0, 3'b101, 2'b10, 32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 32'h130, 32'hAABB_CCDD);
    vecs[13] = mk(1, 0, 3'b101, 2'b01, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h134, 32'hBBCC_DD44);
    vecs[14] = mk(1, 0, 3'b101, 2'b10, 32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'h138, 32'h11AA_BBCC);
    vecs[15] = mk(0, 0, 3'b101, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h13C, 32'h1234_5678);
    vecs[16] = mk(0, 1, 3'b000, 2'b00, 32'h0000_0000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004);

    reset = 1'b1;
    EX_to_ME_valid = 1'b0;
    WB_allowin = 1'b1;
    WB_ExcepEN = 1'b0;
    data_sram_rdata = 32'h0;
    ME_MulRes = 64'h0;
    drive(blank());

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   {31'h0, ME_valid},       32'h0);
    check("rst_to_wb",   {31'h0, ME_to_WB_valid}, 32'h0);
    check("rst_allowin", {31'h0, ME_allowin},     32'h1);
    check("rst_result",  ME_Result,               32'h0);
    check("rst_pc",      ME_PC,                   32'h0);
    check("rst_hi",      ME_HI,                   32'h0);
    check("rst_lo",      ME_LO,                   32'h0);
    check("rst_regwr",   {31'h0, ME_RegWrite},    32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table-driven load alignment / result mux ----
    for (int i = 0; i < NVEC; i++) begin
      e = blank();
      e.mem_to_reg = vecs[i].mem_to_reg;
      e.link       = vecs[i].link;
      e.width      = vecs[i].width;
      e.comb       = vecs[i].comb;
      e.alu        = vecs[i].alu;
      e.rt         = vecs[i].rt;
      e.pc         = vecs[i].pc;
      e.reg_write  = 1'b1;
      e.wreg       = 5'(i + 1);
      issue(e);
      data_sram_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_result", i), ME_Result, vecs[i].exp);
      check($sformatf("vec%0d_pc", i), ME_PC, vecs[i].pc);
      check($sformatf("vec%0d_wreg", i), {27'h0, ME_WriteReg}, 32'(i + 1));
      check($sformatf("vec%0d_regwr", i), {31'h0, ME_RegWrite}, 32'h1);
      drain();
      check($sformatf("vec%0d_empty", i), {31'h0, ME_valid}, 32'h0);
    end

    // ---- MULT then MFHI / MFLO ----
    e = blank();
    e.mul = 1'b1;
    e.pc  = 32'h200;
    issue(e);
    ME_MulRes = 64'h0000_0001_FFFF_FFFE;
    #1;
    check("mul_hi_before", ME_HI, 32'h0);
    drain();
    ME_MulRes = 64'h0;
    check("mul_hi", ME_HI, 32'h0000_0001);
    check("mul_lo", ME_LO, 32'hFFFF_FFFE);

    e = blank();
    e.sp_read = 1'b1;
    e.sel = 2'b10;
    e.reg_write = 1'b1;
    issue(e);
    #1;
    check("mfhi_result", ME_Result, 32'h0000_0001);
    drain();
    e.sel = 2'b01;
    issue(e);
    #1;
    check("mflo_result", ME_Result, 32'hFFFF_FFFE);
    drain();
    check("mflo_no_hilo_change", ME_HI, 32'h0000_0001);

    // ---- MTHI: only HI changes ----
    e = blank();
    e.sp_wri = 1'b1;
    e.sel = 2'b10;
    e.hi = 32'h0000_BEEF;
    e.lo = 32'h0000_1234;
    issue(e);
    drain();
    check("mthi_hi", ME_HI, 32'h0000_BEEF);
    check("mthi_lo", ME_LO, 32'hFFFF_FFFE);

    // ---- DIV held in a 3-cycle stall, commits on release ----
    e = blank();
    e.div = 1'b1;
    e.lo = 32'hAAAA_0001;
    e.hi = 32'hBBBB_0002;
    issue(e);
    WB_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("div_stall%0d_lo", k), ME_LO, 32'hFFFF_FFFE);
      check($sformatf("div_stall%0d_allowin", k), {31'h0, ME_allowin}, 32'h0);
      check($sformatf("div_stall%0d_valid", k), {31'h0, ME_valid}, 32'h1);
    end
    WB_allowin = 1'b1;
    drain();
    check("div_lo", ME_LO, 32'hAAAA_0001);
    check("div_hi", ME_HI, 32'hBBBB_0002);
    check("div_gone", {31'h0, ME_valid}, 32'h0);

    // ---- LW stalled while SRAM data changes and EX offers a new op ----
    e = blank();
    e.mem_to_reg = 1'b1;
    e.width = 3'b101;
    e.alu = 32'h0000_0100;
    e.pc = 32'h400;
    e.reg_write = 1'b1;
    issue(e);
    data_sram_rdata = 32'hDEAD_BEEF;
    WB_allowin = 1'b0;
    #1;
    check("lw_stall_first", ME_Result, 32'hDEAD_BEEF);
    e = blank();
    e.alu = 32'h0000_0077;
    e.pc = 32'h500;
    drive(e);
    EX_to_ME_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h1111_1111 * (k + 1);
      #1;
      check($sformatf("lw_stall%0d_result", k), ME_Result, 32'hDEAD_BEEF);
      check($sformatf("lw_stall%0d_pc", k), ME_PC, 32'h400);
    end
    WB_allowin = 1'b1;
    #1;
    check("lw_release_result", ME_Result, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    EX_to_ME_valid = 1'b0;
    check("after_stall_pc", ME_PC, 32'h500);
    check("after_stall_result", ME_Result, 32'h0000_0077);
    drain();

    // A fresh load after a stall must see the live bus again.
    e = blank();
    e.mem_to_reg = 1'b1;
    e.width = 3'b101;
    e.pc = 32'h600;
    issue(e);
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    check("lw_after_stall", ME_Result, 32'hCAFE_F00D);
    drain();

    // ---- flush while ME holds MTLO ----
    e = blank();
    e.sp_wri = 1'b1;
    e.sel = 2'b01;
    e.lo = 32'h5555_5555;
    issue(e);
    WB_ExcepEN = 1'b1;
    @(posedge clk);
    #1;
    WB_ExcepEN = 1'b0;
    check("flush_mtlo_lo", ME_LO, 32'hAAAA_0001);
    check("flush_mtlo_valid", {31'h0, ME_valid}, 32'h0);
    check("flush_mtlo_regwr", {31'h0, ME_RegWrite}, 32'h0);

    // ---- flush in the same cycle as an incoming load ----
    e = blank();
    e.mem_to_reg = 1'b1;
    e.reg_write = 1'b1;
    e.width = 3'b101;
    @(negedge clk);
    drive(e);
    EX_to_ME_valid = 1'b1;
    WB_ExcepEN = 1'b1;
    @(posedge clk);
    #1;
    EX_to_ME_valid = 1'b0;
    WB_ExcepEN = 1'b0;
    check("flush_load_valid", {31'h0, ME_valid}, 32'h0);
    check("flush_load_regwr", {31'h0, ME_RegWrite}, 32'h0);

    // ---- upstream exception: no GPR write, no HI/LO update ----
    e = blank();
    e.excep = 1'b1;
    e.reg_write = 1'b1;
    e.sp_wri = 1'b1;
    e.sel = 2'b01;
    e.lo = 32'h6666_6666;
    issue(e);
    #1;
    check("excep_flag", {31'h0, ME_Excep}, 32'h1);
    check("excep_regwr", {31'h0, ME_RegWrite}, 32'h0);
    drain();
    check("excep_lo", ME_LO, 32'hAAAA_0001);

    // ---- asynchronous reset in the middle of a stall ----
    e = blank();
    e.mem_to_reg = 1'b1;
    e.width = 3'b101;
    e.pc = 32'h700;
    issue(e);
    WB_allowin = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'h0, ME_valid}, 32'h0);
    check("arst_hi", ME_HI, 32'h0);
    check("arst_lo", ME_LO, 32'h0);
    check("arst_pc", ME_PC, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    WB_allowin = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_me_stage
